// File: rtl/bicubic_tap_pipe.sv
// bicubic_tap_pipe: 3-stage 4-tap cubic/bilinear/nearest resampler, LANES wide, valid/ready flow control
module bicubic_tap_pipe #(
    parameter int PIX_W  = 8,
    parameter int FRAC_W = 8,
    parameter int LANES  = 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_mode,
    input  logic [FRAC_W-1:0]      in_frac,
    input  logic [LANES*PIX_W-1:0] in_p0,
    input  logic [LANES*PIX_W-1:0] in_p1,
    input  logic [LANES*PIX_W-1:0] in_p2,
    input  logic [LANES*PIX_W-1:0] in_p3,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*PIX_W-1:0] out_pix
);
    localparam int D = PIX_W + 4;
    localparam int W = PIX_W + 3 * FRAC_W + 6;
    localparam int S = 3 * FRAC_W + 1;
    localparam logic signed [W-1:0] MAXV = W'((1 << PIX_W) - 1);
    localparam logic signed [W-1:0] HALF = W'(1) <<< (S - 1);
    logic adv, v1, v2;
    logic [1:0] mode1;
    logic [FRAC_W-1:0] frac1;
    logic signed [W-1:0] fw, f2, f3;
    assign adv = out_ready | ~out_valid;
    assign in_ready = adv;
    assign fw = W'(frac1);
    assign f2 = fw * fw;
    assign f3 = f2 * fw;
    always_ff @(posedge CLK) begin
        if (RST) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            out_valid <= 1'b0;
        end else if (adv) begin
            v1 <= in_valid;
            v2 <= v1;
            out_valid <= v2;
        end
    end
    always_ff @(posedge CLK) begin
        if (adv) begin
            mode1 <= in_mode;
            frac1 <= in_frac;
        end
    end
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [PIX_W-1:0] p0, p1, p2, p3, p1_1, near1, r;
        logic signed [D-1:0] z0, z1, z2, z3, a, b, c, d, a1, b1, c1, d1;
        logic signed [W-1:0] aw, bw, cw, dw, base, t0, t1, t2, t3, sum, q;
        assign p0 = in_p0[k*PIX_W +: PIX_W];
        assign p1 = in_p1[k*PIX_W +: PIX_W];
        assign p2 = in_p2[k*PIX_W +: PIX_W];
        assign p3 = in_p3[k*PIX_W +: PIX_W];
        assign z0 = D'(p0);
        assign z1 = D'(p1);
        assign z2 = D'(p2);
        assign z3 = D'(p3);
        // Catmull-Rom coefficients of t, t^2, t^3 (times 2), plus the linear slope
        assign a = z2 - z0;
        assign b = (z0 <<< 1) + (z2 <<< 2) - (z1 <<< 2) - z1 - z3;
        assign c = z1 + (z1 <<< 1) - z0 - z2 - (z2 <<< 1) + z3;
        assign d = z2 - z1;
        always_ff @(posedge CLK) begin
            if (adv) begin
                a1 <= a;
                b1 <= b;
                c1 <= c;
                d1 <= d;
                p1_1 <= p1;
                near1 <= in_frac[FRAC_W-1] ? p2 : p1;
            end
        end
        assign aw = W'(a1);
        assign bw = W'(b1);
        assign cw = W'(c1);
        assign dw = W'(d1);
        assign base = W'(mode1[1] ? near1 : p1_1);
        // every mode is scaled to 2^(3*FRAC_W+1) so one rounding stage serves all
        always_ff @(posedge CLK) begin
            if (adv) begin
                t0 <= base <<< S;
                t1 <= mode1[1] ? '0 : (((mode1[0] ? (dw <<< 1) : aw) * fw) <<< (2 * FRAC_W));
                t2 <= (mode1 == 2'd0) ? ((bw * f2) <<< FRAC_W) : '0;
                t3 <= (mode1 == 2'd0) ? (cw * f3) : '0;
            end
        end
        assign sum = t0 + t1 + t2 + t3 + HALF;
        assign q = sum >>> S;
        always_ff @(posedge CLK) begin
            if (RST) r <= '0;
            else if (adv) r <= q[W-1] ? '0 : (q > MAXV ? {PIX_W{1'b1}} : q[PIX_W-1:0]);
        end
        assign out_pix[k*PIX_W +: PIX_W] = r;
    end
endmodule

// File: tb/tb_bicubic_tap_pipe.sv
// tb_bicubic_tap_pipe: randomized and directed checks of bicubic_tap_pipe against a real-valued model
module tb_bicubic_tap_pipe;
    localparam int PW = 8;
    localparam int FW = 8;
    localparam int L  = 4;
    typedef logic [L*PW-1:0] vec_t;
    typedef struct {vec_t exp; int cyc; bit lat; int lit;} ent_t;
    logic CLK = 0, RST = 1;
    logic in_valid = 0, out_ready = 1;
    logic in_ready, out_valid;
    logic [1:0] in_mode = 0;
    logic [FW-1:0] in_frac = 0;
    vec_t in_p0 = 0, in_p1 = 0, in_p2 = 0, in_p3 = 0, out_pix;
    int checks = 0, errors = 0, cyc = 0, got = 0, lit_next = -1, base_got;
    bit lat_mode = 1, hold = 0, bp_done;
    vec_t held;
    ent_t q[$];
    ent_t e;

    bicubic_tap_pipe #(.PIX_W(PW), .FRAC_W(FW), .LANES(L)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_frac(in_frac), .in_p0(in_p0), .in_p1(in_p1),
        .in_p2(in_p2), .in_p3(in_p3), .out_valid(out_valid),
        .out_ready(out_ready), .out_pix(out_pix)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic int ref_pix(int p0, int p1, int p2, int p3, int f, int m);
        real t, v;
        t = f / real'(1 << FW);
        if (m >= 2) return (f >= (1 << (FW - 1))) ? p2 : p1;
        if (m == 1) v = p1 + (p2 - p1) * t;
        else v = 0.5 * (2 * p1 + (p2 - p0) * t + (2 * p0 - 5 * p1 + 4 * p2 - p3) * t * t
                        + (-p0 + 3 * p1 - 3 * p2 + p3) * t * t * t);
        v = $floor(v + 0.5);
        if (v < 0.0) return 0;
        if (v > real'((1 << PW) - 1)) return (1 << PW) - 1;
        return int'(v);
    endfunction

    function automatic vec_t ref_vec(vec_t a, vec_t b, vec_t c, vec_t d, int f, int m);
        vec_t r;
        for (int k = 0; k < L; k++)
            r[k*PW +: PW] = PW'(ref_pix(a[k*PW +: PW], b[k*PW +: PW], c[k*PW +: PW], d[k*PW +: PW], f, m));
        return r;
    endfunction

    function automatic vec_t rep(int v);
        logic [PW-1:0] x;
        x = PW'(v);
        return {L{x}};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (RST) begin
            q.delete();
            hold = 0;
        end else begin
            if (hold) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_pix", 64'(out_pix), 64'(held));
            end
            hold = out_valid && !out_ready;
            held = out_pix;
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("spurious", 64'(out_valid), 64'd0);
                else begin
                    e = q.pop_front();
                    got++;
                    check("pix", 64'(out_pix), 64'(e.exp));
                    if (e.lat) check("latency", 64'(cyc - e.cyc), 64'd3);
                    if (e.lit >= 0) check("literal", 64'(out_pix[PW-1:0]), 64'(e.lit));
                end
            end
            if (in_valid && in_ready)
                q.push_back('{ref_vec(in_p0, in_p1, in_p2, in_p3, int'(in_frac), int'(in_mode)),
                              cyc, lat_mode, lit_next});
        end
    end

    task automatic drive(int m, int f, vec_t a, vec_t b, vec_t c, vec_t d, int lit);
        bit ok;
        int n;
        in_valid = 1;
        in_mode = 2'(m);
        in_frac = FW'(f);
        in_p0 = a;
        in_p1 = b;
        in_p2 = c;
        in_p3 = d;
        lit_next = lit;
        n = 0;
        do begin
            @(negedge CLK);
            ok = in_ready;
            @(posedge CLK);
            #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) check("in_ready_timeout", 64'(in_ready), 64'd1);
        in_valid = 0;
        lit_next = -1;
    endtask

    task automatic drive_rand();
        drive($urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255),
              $urandom(), $urandom(), $urandom(), $urandom(), -1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (q.size() != 0 || out_valid); i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        RST = 1;
        @(posedge CLK);
        #1;
        RST = 0;
        @(negedge CLK);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_pix", 64'(out_pix), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        do_reset();
        drive(0, 128, rep(10), rep(20), rep(30), rep(40), 25);
        drive(0, 128, rep(0), rep(255), rep(255), rep(0), 255);
        drive(0, 128, rep(255), rep(0), rep(0), rep(255), 0);
        drive(1, 128, rep(50), rep(100), rep(201), rep(250), 151);
        drive(2, 128, rep(50), rep(100), rep(201), rep(250), 201);
        drive(2, 127, rep(50), rep(100), rep(201), rep(250), 100);
        drive(3, 128, rep(50), rep(100), rep(201), rep(250), 201);
        for (int m = 0; m < 4; m++) drive(m, 0, rep(50), rep(100), rep(201), rep(250), 100);
        drive(0, 77, rep(77), rep(77), rep(77), rep(77), 77);
        drive(0, 64, {8'd9, 8'd200, 8'd0, 8'd10}, {8'd3, 8'd100, 8'd255, 8'd20},
              {8'd250, 8'd50, 8'd255, 8'd30}, {8'd1, 8'd0, 8'd0, 8'd40}, 23);
        for (int i = 0; i < 4; i++) drive(0, 64, $urandom(), $urandom(), $urandom(), $urandom(), -1);
        drain();

        lat_mode = 0;
        base_got = got;
        bp_done = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge CLK);
                        #1;
                    end
                    drive_rand();
                end
                bp_done = 1;
            end
            begin
                while (!bp_done) begin
                    @(posedge CLK);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1;
        drain();
        check("bp_count", 64'(got - base_got), 64'd20);

        out_ready = 0;
        for (int i = 0; i < 3; i++) drive_rand();
        repeat (2) @(posedge CLK);
        #1;
        base_got = got;
        out_ready = 1;
        do_reset();
        lat_mode = 1;
        drive(0, 128, rep(10), rep(20), rep(30), rep(40), 25);
        drain();
        check("post_rst_count", 64'(got - base_got), 64'd1);
        check("drain", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bicubic_tap_pipe.md
Name: bicubic_tap_pipe

Overview:
- Parametrised, pipelined 4-tap 1-D resampling kernel for the next-generation Bicubic scaler; the datapath behind the current single-lane Bicubic engine, generalised.
- Accepts four neighbouring pixels per lane plus a fractional phase. Returns one interpolated, clamped pixel per lane, with valid/ready flow control.
- Adds over the current engine: LANES parallel channels, a per-beat mode (cubic, bilinear, nearest), programmable pixel and phase widths, and backpressure.
- The row/column sequencer instantiates one copy for the horizontal pass and one for the vertical pass.

Parameters:
- PIX_W, 8, pixel width in bits (unsigned).
- FRAC_W, 8, phase width; t = frac / 2^FRAC_W, range [0,1).
- LANES, 1, independent channels; all lanes share frac and mode.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  pipeline can accept a beat this cycle.
- in_mode  in  2  0=cubic (Catmull-Rom, a=-0.5), 1=bilinear, 2=nearest, 3=reserved (behaves as nearest).
- in_frac  in  FRAC_W  phase t.
- in_p0..in_p3  in  LANES*PIX_W each  taps P0,P1,P2,P3; lane k occupies bits [k*PIX_W +: PIX_W]; P1 ≤ sample position < P2.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_pix  out  LANES*PIX_W  result per lane, same packing.

Behaviour:
- Reset: synchronous, active-high. Clears all stage valids. out_valid=0, out_pix=0, in_ready=1 on the cycle after RST is sampled high.
- Pipeline: 3 register stages. S1 captures the inputs and the tap differences. S2 holds the polynomial partial products. S3 does rounding, clamping and drives the outputs.
- Mode and frac travel with the beat, so consecutive beats may differ in mode.
- Flow control:
  - Global advance enable: adv = out_ready | ~out_valid.
  - in_ready = adv (combinational).
  - A beat transfers in when in_valid & in_ready, and out when out_valid & out_ready.
  - Latency from input handshake to out_valid is exactly 3 cycles when out_ready is held high.
  - Throughput is 1 beat/cycle.
  - With adv=0 every stage holds, and out_pix/out_valid stay stable.
  - Bubbles (in_valid=0) propagate as invalid stages. They are squeezed out only while out_valid=0.
- Arithmetic, per lane, with exact rational value V:
  - Cubic: V = 0.5*(2P1 + (P2-P0)t + (2P0-5P1+4P2-P3)t^2 + (-P0+3P1-3P2+P3)t^3).
  - Bilinear: V = P1 + (P2-P1)t.
  - Nearest: result = P2 if frac ≥ 2^(FRAC_W-1), else P1. No rounding is applied.
- Rounding and clamping:
  - Result = floor(V + 0.5), i.e. round half up, also for negative V.
  - Then clamp to [0, 2^PIX_W-1].
  - The cubic intermediate is signed with at least PIX_W+3*FRAC_W+5 bits. No intermediate truncation is allowed; the result must be bit-exact against the rational model.
- Boundaries:
  - frac=0 gives exactly P1 in all modes.
  - Overshoot clamps to max; undershoot clamps to 0.
  - Equal taps return that tap value.
  - Lanes never interact.
- Simultaneous events:
  - An input and an output handshake in the same cycle are both honoured, with no lost or duplicated beat.
  - RST high overrides everything. In-flight beats are discarded and are never emitted after reset.

Test Plan:
- Cubic, FRAC_W=8, taps 10,20,30,40, frac=128 -> out_pix=25 exactly 3 cycles after the handshake, out_ready=1.
- Cubic overshoot/undershoot: taps 0,255,255,0 at frac=128 -> 255 (V=286.875 clamped). Then taps 255,0,0,255 at frac=128 -> 0 (V=-31.875 clamped).
- Mode mix: bilinear P1=100, P2=201, frac=128 -> 151 (150.5 rounds up). Nearest with same taps: frac=128 -> 201, frac=127 -> 100. Any mode at frac=0 -> 100.
- Backpressure: stream 20 beats of random taps/modes while toggling out_ready with a pseudo-random pattern -> all 20 results emerge in order, match the rational model, and out_pix stays stable while out_valid=1 & out_ready=0.
- LANES=4: each lane gets different taps, with shared frac=64, cubic -> each lane matches its scalar model independently.
- Reset mid-stream: assert RST for 1 cycle with 3 beats in flight -> out_valid=0 the following cycle, none of the 3 beats ever appears, and the next input yields a correct result after 3 cycles.
